// File: rtl/ad9363_rx_pkg.sv
// ad9363_rx_pkg: shared FSM state type, FIFO sizing constant and I/Q sign-extend/pack helpers
package ad9363_rx_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int FIFO_DEPTH_DEF = 16;
    localparam int PTR_W          = $clog2(FIFO_DEPTH_DEF);

    // sign-extend a w-bit two's complement value held zero-extended in 16 bits
    function automatic logic [15:0] sext16(input logic [15:0] x, input int w);
        return x[4'(w - 1)] ? (x | (16'hFFFF << w)) : x;
    endfunction

    function automatic logic [31:0] pack_iq(input logic [15:0] i, input logic [15:0] q, input int w);
        return {sext16(q, w), sext16(i, w)};
    endfunction

endpackage

// File: rtl/ad9363_sync_fifo.sv
// ad9363_sync_fifo: single-clock FIFO whose head lives in a registered output stage; the output register counts toward DEPTH
module ad9363_sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_i,
    output logic [W-1:0] rd_data_o,
    output logic         rd_valid_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         free2_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, avail;
    logic [W-1:0]  dout_q;
    logic          vld_q, pop, load, from_mem, mem_wr;

    // flags reflect occupancy after this cycle's read, so a full FIFO being read still takes a write
    always_comb begin
        pop      = vld_q && rd_i;
        load     = !vld_q || rd_i;
        from_mem = cnt_q != (AW+1)'(vld_q);
        mem_wr   = wr_i && !(load && !from_mem);
        avail    = cnt_q - (AW+1)'(pop);
    end

    assign full_o     = avail == (AW+1)'(DEPTH);
    assign free2_o    = avail <= (AW+1)'(DEPTH - 2);
    assign empty_o    = cnt_q == '0;
    assign rd_data_o  = dout_q;
    assign rd_valid_o = vld_q;

    // storage array; writes bypass it when the output stage is free and the array is empty
    always_ff @(posedge clk) begin
        if (mem_wr) mem_q[wp_q] <= wr_data_i;
    end

    // pointers, occupancy and the registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            cnt_q <= cnt_q + (AW+1)'(wr_i) - (AW+1)'(pop);
            wp_q  <= wp_q + AW'(mem_wr);
            rp_q  <= rp_q + AW'(load && from_mem);
            if (load) vld_q <= from_mem || wr_i;
            if (load && (from_mem || wr_i)) dout_q <= from_mem ? mem_q[rp_q] : wr_data_i;
        end
    end

endmodule

// File: rtl/ad9363_rx_packer.sv
// ad9363_rx_packer: packs AD9363 I/Q pairs into 32-bit words and streams fixed-length AXI-Stream packets
// Define AD9363_RX_TIMESTAMP_EN to prefix every packet with a 32-bit sample-count header word.
module ad9363_rx_packer
    import ad9363_rx_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int PKT_LEN    = 256,
    parameter int FIFO_DEPTH = 1 << PTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [DATA_W-1:0] s_i_data,
    input  logic [DATA_W-1:0] s_q_data,
    input  logic              s_valid,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    state_t      state_q;
    logic [15:0] cnt_q, cnt_d, drop_q;
    logic        ovf_q;
    logic        smp, acc, drop, pad, wr, pay, last, idle_ok;
    logic        full, empty;
    logic [31:0] word;
    logic [32:0] wdata, rdata;

    assign word = pack_iq(16'(s_i_data), 16'(s_q_data), DATA_W);

`ifdef AD9363_RX_TIMESTAMP_EN
    logic [31:0] ts_q, hold_data_q;
    logic        hold_q, free2, start, hdr;

    // a packet-start sample first writes the header, then its payload from the hold register next cycle
    always_comb begin
        smp     = s_valid && state_q == RUN;
        last    = cnt_q == 16'(PKT_LEN - 1);
        start   = cnt_q == '0 && !hold_q;
        hdr     = smp && start && free2;
        acc     = smp && !start && !full;
        drop    = smp && (start ? !free2 : full);
        pad     = state_q == DRAIN && !hold_q && cnt_q != '0 && !full;
        pay     = hold_q || acc || pad;
        wr      = hdr || pay;
        wdata   = hdr ? {1'b0, ts_q} : {last, hold_q ? hold_data_q : acc ? word : 32'h0};
        idle_ok = cnt_q == '0 && !hold_q && empty && !wr;
    end

    // free-running sample counter and one-deep hold for the sample behind a header
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q        <= '0;
            hold_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            ts_q        <= ts_q + 32'(smp);
            hold_q      <= hdr;
            hold_data_q <= hdr ? word : hold_data_q;
        end
    end
`else
    // accept a sample while running, or pad with zeros while draining a partial packet
    always_comb begin
        smp     = s_valid && state_q == RUN;
        last    = cnt_q == 16'(PKT_LEN - 1);
        acc     = smp && !full;
        drop    = smp && full;
        pad     = state_q == DRAIN && cnt_q != '0 && !full;
        pay     = acc || pad;
        wr      = pay;
        wdata   = {last, acc ? word : 32'h0};
        idle_ok = cnt_q == '0 && empty && !wr;
    end
`endif

    // write-side payload index; tlast is tagged onto the word as it enters the FIFO
    assign cnt_d = pay ? (last ? '0 : cnt_q + 16'd1) : cnt_q;

    ad9363_sync_fifo #(.W(33), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (wr),
        .wr_data_i (wdata),
        .rd_i      (m_axis_tready),
        .rd_data_o (rdata),
        .rd_valid_o(m_axis_tvalid),
        .full_o    (full),
        .empty_o   (empty),
`ifdef AD9363_RX_TIMESTAMP_EN
        .free2_o   (free2)
`else
        .free2_o   ()
`endif
    );

    assign m_axis_tdata = rdata[31:0];
    assign m_axis_tlast = rdata[32];
    assign overflow     = ovf_q;
    assign drop_cnt     = drop_q;

    // capture FSM: a started packet is always completed before returning to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else begin
            unique case (state_q)
                IDLE:    if (enable) state_q <= RUN;
                RUN:     if (!enable) state_q <= idle_ok ? IDLE : DRAIN;
                default: if (idle_ok) state_q <= IDLE;
            endcase
        end
    end

    // payload counter plus sticky overflow and saturating drop count; clear wins over a same-cycle drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= clear ? 1'b0 : (ovf_q || drop);
            drop_q <= clear ? '0 : (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        end
    end

endmodule

// File: tb/tb_ad9363_rx_packer.sv
// tb_ad9363_rx_packer: scoreboard bench for ad9363_rx_packer with PKT_LEN=4; also covers AD9363_RX_TIMESTAMP_EN builds
module tb_ad9363_rx_packer;

    localparam int PL = 4;
`ifdef AD9363_RX_TIMESTAMP_EN
    localparam int KEEP  = 12;
    localparam int NDROP = 8;
`else
    localparam int KEEP  = 16;
    localparam int NDROP = 4;
`endif

    logic        clk = 0, rst_n = 0, enable = 0, clear = 0, s_valid = 0, tready = 0;
    logic [11:0] s_i = 0, s_q = 0;
    logic [31:0] tdata;
    logic        tvalid, tlast, overflow;
    logic [15:0] drop_cnt;

    logic [32:0] sb[$];
    logic [32:0] head;
    logic [31:0] m_ts = 0;
    int          m_cnt = 0;
    int          n_chk = 0, n_bad = 0;
    logic        tv_after;

    always #5 clk = ~clk;

    ad9363_rx_packer #(.DATA_W(12), .PKT_LEN(PL), .FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clear        (clear),
        .s_i_data     (s_i),
        .s_q_data     (s_q),
        .s_valid      (s_valid),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tb_pack(input logic [11:0] i, input logic [11:0] q);
        return {{4{q[11]}}, q, {4{i[11]}}, i};
    endfunction

    task automatic expect_word(input logic [31:0] w);
`ifdef AD9363_RX_TIMESTAMP_EN
        if (m_cnt == 0) sb.push_back({1'b0, m_ts});
`endif
        sb.push_back({m_cnt == PL - 1, w});
        m_cnt = (m_cnt + 1) % PL;
    endtask

    // mode: 0 dropped while running, 1 accepted, 2 ignored (not running)
    task automatic send(input logic [11:0] i, input logic [11:0] q, input int mode);
        s_i = i;
        s_q = q;
        s_valid = 1;
        if (mode == 1) expect_word(tb_pack(i, q));
        if (mode != 2) m_ts++;
        @(posedge clk); #1;
        s_valid = 0;
        tv_after = tvalid;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int max);
        for (int k = 0; k < max && sb.size() != 0; k++) @(posedge clk);
        #1;
        check("drain", 64'(sb.size()), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && tvalid && tready) begin
            if (sb.size() == 0) check("unexpected_beat", 64'(tvalid), 0);
            else begin
                head = sb.pop_front();
                check("tdata", 64'(tdata), 64'(head[31:0]));
                check("tlast", 64'(tlast), 64'(head[32]));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(tvalid), 0);
        check("rst_tlast", 64'(tlast), 0);
        check("rst_tdata", 64'(tdata), 0);
        check("rst_overflow", 64'(overflow), 0);
        check("rst_drop_cnt", 64'(drop_cnt), 0);
        rst_n = 1;
        @(posedge clk); #1;

        // two full packets of extreme values at full throughput
        tready = 1;
        enable = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            send(12'h7FF, 12'h800, 1);
            if (k == 0) check("latency_tvalid", 64'(tv_after), 1);
        end
        check("t1_overflow", 64'(overflow), 0);
        wait_drain(50);
        enable = 0;
        repeat (4) @(posedge clk);
        #1;
        check("t1_idle_tvalid", 64'(tvalid), 0);

        // stall the sink until the buffer overflows
        tready = 0;
        enable = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) send(12'(k * 37 + 1), 12'(12'hF00 - k), k < KEEP ? 1 : 0);
        check("t2_overflow", 64'(overflow), 1);
        check("t2_drop_cnt", 64'(drop_cnt), NDROP);
        head = sb[0];
        check("t2_held_tdata", 64'(tdata), 64'(head[31:0]));
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        check("t2_clr_overflow", 64'(overflow), 0);
        check("t2_clr_drop_cnt", 64'(drop_cnt), 0);
        tready = 1;
        send(12'h123, 12'hABC, 1);
        check("t2_full_rd_drop", 64'(drop_cnt), 0);
        for (int k = 0; k < 3; k++) send(12'(k + 40), 12'(12'h900 + k), 1);
        wait_drain(100);

        // stop mid-packet: remaining beats are zero padding
        send(12'h001, 12'hFFF, 1);
        send(12'h002, 12'h003, 1);
        enable = 0;
        while (m_cnt != 0) expect_word(32'h0);
        wait_drain(50);
        repeat (3) @(posedge clk);
        #1;
        check("t3_idle_tvalid", 64'(tvalid), 0);
        send(12'h055, 12'h055, 2);
        repeat (6) @(posedge clk);
        #1;
        check("t3_no_capture", 64'(tvalid), 0);

        // reset mid-packet abandons it
        tready = 0;
        enable = 1;
        @(posedge clk); #1;
        send(12'h007, 12'h007, 1);
        send(12'h008, 12'h008, 1);
        check("t4_pre_rst_tvalid", 64'(tvalid), 1);
        rst_n = 0;
        #1;
        check("t4_async_tvalid", 64'(tvalid), 0);
        sb.delete();
        m_cnt = 0;
        m_ts = 0;
        @(posedge clk); #1;
        rst_n = 1;
        tready = 1;
        @(posedge clk); #1;
        for (int k = 0; k < PL; k++) send(12'(k + 100), 12'(12'hC00 + k), 1);
        wait_drain(50);
        enable = 0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
